// File: rtl/ascon_pack.sv
// Shared sizing, state encoding and helpers for the Ascon block sequencer.
package ascon_pack;

    localparam int unsigned BLK_W      = 64;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned WDOG_W     = 5;
    localparam int unsigned WDOG_LIMIT = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_INIT,
        ST_AD_REQ,
        ST_AD_WAIT,
        ST_PT_REQ,
        ST_PT_WAIT,
        ST_DONE
    } seq_state_e;

    // States in which the watchdog runs while the core owes us something.
    function automatic logic is_watched(seq_state_e s);
        return (s == ST_START) || (s == ST_WAIT_INIT) || (s == ST_AD_WAIT) || (s == ST_PT_WAIT);
    endfunction

endpackage

// File: rtl/ascon_block_sequencer_if.sv
// Signal bundle between the block sequencer, its block source, the permutation core and the ciphertext sink.
interface ascon_block_sequencer_if;
    import ascon_pack::*;

    logic                 start_i;
    logic [CNT_W-1:0]     nb_ad_i;
    logic [CNT_W-1:0]     nb_pt_i;
    logic                 blk_valid_i;
    logic [BLK_W-1:0]     blk_data_i;
    logic                 blk_ready_o;
    logic                 core_start_o;
    logic [BLK_W-1:0]     core_data_o;
    logic                 core_data_valid_o;
    logic                 core_last_o;
    logic                 core_end_init_i;
    logic                 core_end_associate_i;
    logic                 core_end_cipher_i;
    logic                 core_end_i;
    logic                 core_cipher_valid_i;
    logic [BLK_W-1:0]     core_cipher_i;
    logic                 out_valid_o;
    logic [BLK_W-1:0]     out_data_o;
    logic                 out_ready_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 error_o;

    modport slave (
        input  start_i, nb_ad_i, nb_pt_i, blk_valid_i, blk_data_i,
        input  core_end_init_i, core_end_associate_i, core_end_cipher_i, core_end_i,
        input  core_cipher_valid_i, core_cipher_i, out_ready_i,
        output blk_ready_o, core_start_o, core_data_o, core_data_valid_o, core_last_o,
        output out_valid_o, out_data_o, busy_o, done_o, error_o
    );

    modport master (
        output start_i, nb_ad_i, nb_pt_i, blk_valid_i, blk_data_i,
        output core_end_init_i, core_end_associate_i, core_end_cipher_i, core_end_i,
        output core_cipher_valid_i, core_cipher_i, out_ready_i,
        input  blk_ready_o, core_start_o, core_data_o, core_data_valid_o, core_last_o,
        input  out_valid_o, out_data_o, busy_o, done_o, error_o
    );

endinterface

// File: rtl/ascon_out_buf.sv
// One-entry valid/ready ciphertext register; a load into a full, stalled entry is dropped and flagged.
module ascon_out_buf
    import ascon_pack::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BLK_W-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [BLK_W-1:0] data,
    output logic             valid_next_c,
    output logic             overflow_c
);

    logic take;

    assign take         = load & (~valid | ready);
    assign valid_next_c = load | (valid & ~ready);
    assign overflow_c   = load & valid & ~ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= valid_next_c;
            if (take) begin
                data <= load_data;
            end
        end
    end

endmodule

// File: rtl/ascon_block_sequencer.sv
// Feeds AD then PT blocks to the Ascon permutation core, tracks its phase-done pulses and buffers ciphertext.
module ascon_block_sequencer
    import ascon_pack::*;
(
    input  logic                   clock_i,
    input  logic                   reset_i,
    ascon_block_sequencer_if.slave bus
);

    seq_state_e        state, state_next;
    logic [CNT_W-1:0]  ad_cnt, ad_cnt_next;
    logic [CNT_W-1:0]  pt_cnt, pt_cnt_next;
    logic [WDOG_W-1:0] wdog, wdog_next;
    logic [BLK_W-1:0]  core_data_next;
    logic              core_data_valid_next;
    logic              core_last_next;
    logic              error_next;
    logic              blk_ready_next;
    logic              core_start_next;
    logic              busy_next;
    logic              done_next;
    logic              handshake;
    logic              wdog_expire;
    logic              buf_valid_next;
    logic              buf_overflow;

    ascon_out_buf u_out_buf (
        .clk          (clock_i),
        .rst          (reset_i),
        .load         (bus.core_cipher_valid_i),
        .load_data    (bus.core_cipher_i),
        .ready        (bus.out_ready_i),
        .valid        (bus.out_valid_o),
        .data         (bus.out_data_o),
        .valid_next_c (buf_valid_next),
        .overflow_c   (buf_overflow)
    );

    assign handshake   = bus.blk_valid_i & bus.blk_ready_o;
    // Bail on the cycle the count would reach the limit, so done lands exactly LIMIT cycles after entry.
    assign wdog_expire = (wdog == WDOG_W'(WDOG_LIMIT - 1));

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state                 <= ST_IDLE;
            ad_cnt                <= '0;
            pt_cnt                <= '0;
            wdog                  <= '0;
            bus.blk_ready_o       <= 1'b0;
            bus.core_start_o      <= 1'b0;
            bus.core_data_o       <= '0;
            bus.core_data_valid_o <= 1'b0;
            bus.core_last_o       <= 1'b0;
            bus.busy_o            <= 1'b0;
            bus.done_o            <= 1'b0;
            bus.error_o           <= 1'b0;
        end else begin
            state                 <= state_next;
            ad_cnt                <= ad_cnt_next;
            pt_cnt                <= pt_cnt_next;
            wdog                  <= wdog_next;
            bus.blk_ready_o       <= blk_ready_next;
            bus.core_start_o      <= core_start_next;
            bus.core_data_o       <= core_data_next;
            bus.core_data_valid_o <= core_data_valid_next;
            bus.core_last_o       <= core_last_next;
            bus.busy_o            <= busy_next;
            bus.done_o            <= done_next;
            bus.error_o           <= error_next;
        end
    end

    always_comb begin
        state_next           = state;
        ad_cnt_next          = ad_cnt;
        pt_cnt_next          = pt_cnt;
        error_next           = bus.error_o;
        core_data_next       = bus.core_data_o;
        core_last_next       = bus.core_last_o;
        core_data_valid_next = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start_i) begin
                    ad_cnt_next    = bus.nb_ad_i;
                    pt_cnt_next    = bus.nb_pt_i;
                    core_last_next = 1'b0;
                    if (bus.nb_pt_i == '0) begin
                        error_next = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        error_next = 1'b0;
                        state_next = ST_START;
                    end
                end
            end
            ST_START: state_next = ST_WAIT_INIT;
            ST_WAIT_INIT: begin
                if (bus.core_end_init_i) begin
                    state_next = (ad_cnt != '0) ? ST_AD_REQ : ST_PT_REQ;
                end else if (wdog_expire) begin
                    error_next = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_AD_REQ: begin
                if (handshake) begin
                    core_data_next       = bus.blk_data_i;
                    core_data_valid_next = 1'b1;
                    core_last_next       = 1'b0;
                    ad_cnt_next          = ad_cnt - CNT_W'(1);
                    state_next           = ST_AD_WAIT;
                end
            end
            ST_AD_WAIT: begin
                if (bus.core_end_associate_i) begin
                    state_next = (ad_cnt != '0) ? ST_AD_REQ : ST_PT_REQ;
                end else if (wdog_expire) begin
                    error_next = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_PT_REQ: begin
                if (handshake) begin
                    core_data_next       = bus.blk_data_i;
                    core_data_valid_next = 1'b1;
                    core_last_next       = (pt_cnt == CNT_W'(1));
                    pt_cnt_next          = pt_cnt - CNT_W'(1);
                    state_next           = ST_PT_WAIT;
                end
            end
            ST_PT_WAIT: begin
                // The final block waits for end-of-message; earlier ones for end-of-cipher.
                if (bus.core_last_o ? bus.core_end_i : bus.core_end_cipher_i) begin
                    state_next = bus.core_last_o ? ST_DONE : ST_PT_REQ;
                end else if (wdog_expire) begin
                    error_next = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        if (buf_overflow) begin
            error_next = 1'b1;
        end

        wdog_next       = (is_watched(state) && (state_next == state)) ? wdog + WDOG_W'(1) : '0;
        blk_ready_next  = (state_next == ST_AD_REQ) || ((state_next == ST_PT_REQ) && !buf_valid_next);
        core_start_next = (state_next == ST_START);
        busy_next       = (state_next != ST_IDLE);
        done_next       = (state_next == ST_DONE);
    end

endmodule

// File: tb/tb_ascon_block_sequencer.sv
// Scoreboard bench for ascon_block_sequencer: a block source, a latency-modelled core and a ciphertext sink.
module tb_ascon_block_sequencer;

    localparam int          CORE_LAT = 6;
    localparam logic [63:0] KEY      = 64'h0123_4567_89ab_cdef;

    typedef struct packed {
        logic [63:0] data;
        logic        is_pt;
        logic        last;
    } blk_t;

    typedef enum int {EV_NONE, EV_INIT, EV_ASSOC, EV_CIPHER, EV_END} ev_e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    ascon_block_sequencer_if bus();

    ascon_block_sequencer dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_vec = 0;
    int          n_miss = 0;
    blk_t        src_q[$];
    blk_t        exp_blk_q[$];
    logic [63:0] exp_out_q[$];
    int          n_start, n_dv, n_beat, n_done, dv_cyc;
    bit          core_mute = 1'b0;
    bit          force_cipher = 1'b0;
    ev_e         pend = EV_NONE;
    int          timer = 0;
    logic [63:0] pend_data = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        n_start = 0;
        n_dv    = 0;
        n_beat  = 0;
        n_done  = 0;
        dv_cyc  = 0;
    endtask

    task automatic load_msg(input int ad, input int pt, input bit expect_out);
        blk_t b;
        for (int i = 0; i < ad; i++) begin
            b = '{data: {$urandom, $urandom}, is_pt: 1'b0, last: 1'b0};
            src_q.push_back(b);
        end
        for (int i = 0; i < pt; i++) begin
            b = '{data: {$urandom, $urandom}, is_pt: 1'b1, last: (i == pt - 1)};
            src_q.push_back(b);
            if (expect_out) exp_out_q.push_back(b.data ^ KEY);
        end
    endtask

    task automatic start_msg(input int ad, input int pt);
        bus.nb_ad_i = 4'(ad);
        bus.nb_pt_i = 4'(pt);
        bus.start_i = 1'b1;
        step(1);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit, output int waited);
        waited = 0;
        while (!bus.done_o && waited < limit) begin
            step(1);
            waited++;
        end
        check_val(tag, 64'(bus.done_o), 64'd1);
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_busy"},      64'(bus.busy_o),            64'd0);
        check_val({tag, "_blk_ready"}, 64'(bus.blk_ready_o),       64'd0);
        check_val({tag, "_core_start"},64'(bus.core_start_o),      64'd0);
        check_val({tag, "_core_data"}, bus.core_data_o,            64'd0);
        check_val({tag, "_core_dv"},   64'(bus.core_data_valid_o), 64'd0);
        check_val({tag, "_core_last"}, 64'(bus.core_last_o),       64'd0);
        check_val({tag, "_out_valid"}, 64'(bus.out_valid_o),       64'd0);
        check_val({tag, "_out_data"},  bus.out_data_o,             64'd0);
        check_val({tag, "_done"},      64'(bus.done_o),            64'd0);
        check_val({tag, "_error"},     64'(bus.error_o),           64'd0);
    endtask

    // Upstream block source: present the queue head, move it to the scoreboard when accepted.
    initial begin
        bus.blk_valid_i = 1'b0;
        bus.blk_data_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.blk_valid_i = (src_q.size() != 0);
            bus.blk_data_i  = (src_q.size() != 0) ? src_q[0].data : 64'd0;
            @(negedge clk);
            if (bus.blk_valid_i && bus.blk_ready_o && src_q.size() != 0) begin
                exp_blk_q.push_back(src_q.pop_front());
            end
        end
    end

    // Core model, phase-pulse generator and downstream monitor, all on the falling edge.
    always @(negedge clk) begin
        blk_t e;
        bus.core_end_init_i      = 1'b0;
        bus.core_end_associate_i = 1'b0;
        bus.core_end_cipher_i    = 1'b0;
        bus.core_end_i           = 1'b0;
        bus.core_cipher_valid_i  = 1'b0;
        if (timer != 0) begin
            timer--;
            if (timer == 0) begin
                case (pend)
                    EV_INIT:   bus.core_end_init_i = 1'b1;
                    EV_ASSOC:  bus.core_end_associate_i = 1'b1;
                    EV_CIPHER: begin
                        bus.core_cipher_valid_i = 1'b1;
                        bus.core_cipher_i       = pend_data;
                        bus.core_end_cipher_i   = 1'b1;
                    end
                    EV_END: begin
                        bus.core_cipher_valid_i = 1'b1;
                        bus.core_cipher_i       = pend_data;
                        bus.core_end_i          = 1'b1;
                    end
                    default: ;
                endcase
                pend = EV_NONE;
            end
        end
        if (force_cipher) begin
            bus.core_cipher_valid_i = 1'b1;
            bus.core_cipher_i       = 64'hbad0_bad0_bad0_bad0;
            force_cipher            = 1'b0;
        end
        if (bus.core_start_o) begin
            n_start++;
            pend  = EV_INIT;
            timer = CORE_LAT;
        end
        if (bus.core_data_valid_o) begin
            n_dv++;
            dv_cyc = cyc;
            check_val("dv_expected", 64'(exp_blk_q.size() != 0), 64'd1);
            if (exp_blk_q.size() != 0) begin
                e = exp_blk_q.pop_front();
                check_val("core_data", bus.core_data_o, e.data);
                check_val("core_last", 64'(bus.core_last_o), 64'(e.last));
                if (!core_mute) begin
                    timer     = CORE_LAT;
                    pend      = !e.is_pt ? EV_ASSOC : (e.last ? EV_END : EV_CIPHER);
                    pend_data = bus.core_data_o ^ KEY;
                end
            end
        end
        if (bus.done_o) n_done++;
        if (bus.out_valid_o && bus.out_ready_i) begin
            n_beat++;
            check_val("out_expected", 64'(exp_out_q.size() != 0), 64'd1);
            if (exp_out_q.size() != 0) begin
                check_val("out_data", bus.out_data_o, exp_out_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        int w;
        int done_cyc;
        bus.start_i     = 1'b0;
        bus.nb_ad_i     = '0;
        bus.nb_pt_i     = '0;
        bus.out_ready_i = 1'b1;
        bus.core_cipher_i = '0;
        clear_counts();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        check_quiet("rst");

        // Two AD blocks, three PT blocks.
        clear_counts();
        load_msg(2, 3, 1'b1);
        start_msg(2, 3);
        wait_done("s1_done", 300, w);
        check_val("s1_error", 64'(bus.error_o), 64'd0);
        step(3);
        check_val("s1_n_start", 64'(n_start), 64'd1);
        check_val("s1_n_dv",    64'(n_dv),    64'd5);
        check_val("s1_n_beat",  64'(n_beat),  64'd3);
        check_val("s1_n_done",  64'(n_done),  64'd1);
        check_val("s1_busy",    64'(bus.busy_o), 64'd0);
        check_val("s1_blk_q",   64'(exp_blk_q.size() + src_q.size()), 64'd0);

        // No AD: init goes straight to the PT phase.
        clear_counts();
        load_msg(0, 1, 1'b1);
        start_msg(0, 1);
        wait_done("s2_done", 100, w);
        check_val("s2_error", 64'(bus.error_o), 64'd0);
        step(3);
        check_val("s2_n_start", 64'(n_start), 64'd1);
        check_val("s2_n_dv",    64'(n_dv),    64'd1);
        check_val("s2_n_beat",  64'(n_beat),  64'd1);
        check_val("s2_n_done",  64'(n_done),  64'd1);

        // Zero PT blocks: immediate error completion, no core start.
        clear_counts();
        start_msg(3, 0);
        wait_done("s3_done", 2, w);
        check_val("s3_done_lat", 64'(w), 64'd0);
        check_val("s3_error", 64'(bus.error_o), 64'd1);
        step(3);
        check_val("s3_n_start", 64'(n_start), 64'd0);
        check_val("s3_n_done",  64'(n_done),  64'd1);

        // Core silent after a PT block: watchdog ends the message.
        clear_counts();
        core_mute = 1'b1;
        load_msg(0, 1, 1'b0);
        start_msg(0, 1);
        wait_done("s4_done", 100, w);
        done_cyc = cyc;
        check_val("s4_wdog_cycles", 64'(done_cyc - dv_cyc), 64'd31);
        check_val("s4_error", 64'(bus.error_o), 64'd1);
        step(3);
        core_mute = 1'b0;
        check_val("s4_n_dv",   64'(n_dv),   64'd1);
        check_val("s4_n_beat", 64'(n_beat), 64'd0);

        // Stalled sink: PT_REQ holds off, a second cipher is dropped with error.
        clear_counts();
        bus.out_ready_i = 1'b0;
        load_msg(0, 2, 1'b1);
        start_msg(0, 2);
        w = 0;
        while (!bus.out_valid_o && w < 100) begin
            step(1);
            w++;
        end
        check_val("s5_buffered", 64'(bus.out_valid_o), 64'd1);
        step(2);
        check_val("s5_blk_ready", 64'(bus.blk_ready_o), 64'd0);
        check_val("s5_busy",      64'(bus.busy_o),      64'd1);
        check_val("s5_n_dv_hold", 64'(n_dv),            64'd1);
        force_cipher = 1'b1;
        step(2);
        check_val("s5_error",     64'(bus.error_o),     64'd1);
        check_val("s5_out_valid", 64'(bus.out_valid_o), 64'd1);
        check_val("s5_kept_data", bus.out_data_o, exp_out_q[0]);
        bus.out_ready_i = 1'b1;
        wait_done("s5_done", 100, w);
        check_val("s5_error_sticky", 64'(bus.error_o), 64'd1);
        step(3);
        check_val("s5_n_dv",   64'(n_dv),   64'd2);
        check_val("s5_n_beat", 64'(n_beat), 64'd2);

        // Reset mid-message in AD_WAIT, then a normal run.
        clear_counts();
        load_msg(2, 1, 1'b1);
        start_msg(2, 1);
        w = 0;
        while (n_dv == 0 && w < 100) begin
            step(1);
            w++;
        end
        check_val("s6_in_ad_wait_busy", 64'(bus.busy_o),  64'd1);
        check_val("s6_error_cleared",   64'(bus.error_o), 64'd0);
        rst = 1'b1;
        src_q.delete();
        exp_blk_q.delete();
        exp_out_q.delete();
        step(1);
        rst = 1'b0;
        check_quiet("s6_rst");
        step(10);
        check_val("s6_no_done", 64'(n_done), 64'd0);
        clear_counts();
        load_msg(1, 2, 1'b1);
        start_msg(1, 2);
        wait_done("s6_done", 200, w);
        check_val("s6_error", 64'(bus.error_o), 64'd0);
        step(3);
        check_val("s6_n_start", 64'(n_start), 64'd1);
        check_val("s6_n_dv",    64'(n_dv),    64'd3);
        check_val("s6_n_beat",  64'(n_beat),  64'd2);
        check_val("s6_n_done",  64'(n_done),  64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
